// File: rtl/ahb_matrix_pkg.sv
// Shared AHB constants and holding-register payload for the matrix input stage.
package ahb_matrix_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TRANS_W = 2;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 3;
  localparam int unsigned PROT_W  = 4;
  localparam int unsigned RESP_W  = 2;

  localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [TRANS_W-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [TRANS_W-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [RESP_W-1:0] HRESP_OKAY  = 2'b00;
  localparam logic [RESP_W-1:0] HRESP_ERROR = 2'b01;

  // Address-phase fields captured by the holding register (user field kept apart: width is a parameter)
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [TRANS_W-1:0] trans;
    logic               write;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [PROT_W-1:0]  prot;
    logic               mastlock;
  } ahb_addr_phase_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_DATA = 2'b10
  } in_state_e;

endpackage

// File: rtl/ahb_matrix_input_hold.sv
// AHB matrix input stage: holds an address phase until the decoder accepts it.
// Optional macro AHB_MATRIX_IN_USER_EN holds and muxes HAUSERS as well.
module ahb_matrix_input_hold
  import ahb_matrix_pkg::*;
#(
  parameter int unsigned USER_W = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSELS,
  input  logic [ADDR_W-1:0]   HADDRS,
  input  logic [TRANS_W-1:0]  HTRANSS,
  input  logic                HWRITES,
  input  logic [SIZE_W-1:0]   HSIZES,
  input  logic [BURST_W-1:0]  HBURSTS,
  input  logic [PROT_W-1:0]   HPROTS,
  input  logic                HMASTLOCKS,
  input  logic [USER_W-1:0]   HAUSERS,
  input  logic                HREADYS,
  input  logic                active_op,
  input  logic                readyout_op,
  input  logic [RESP_W-1:0]   resp_op,
  output logic                HREADYOUTS,
  output logic [RESP_W-1:0]   HRESPS,
  output logic                sel_op,
  output logic [ADDR_W-1:0]   addr_op,
  output logic [TRANS_W-1:0]  trans_op,
  output logic                write_op,
  output logic [SIZE_W-1:0]   size_op,
  output logic [BURST_W-1:0]  burst_op,
  output logic [PROT_W-1:0]   prot_op,
  output logic                mastlock_op,
  output logic [USER_W-1:0]   auser_op,
  output logic                held_tran_op
);

  in_state_e       state_q;
  in_state_e       state_d;
  ahb_addr_phase_t live_c;
  ahb_addr_phase_t hold_q;
  ahb_addr_phase_t pres_c;
  logic            load_c;
  logic            pend_c;
  logic            dphase_c;
  logic            pend_nx_c;
  logic            dphase_nx_c;

  assign load_c   = HSELS & HTRANSS[1] & HREADYS;
  assign pend_c   = (state_q == ST_HOLD);
  assign dphase_c = (state_q == ST_DATA);

  assign live_c = '{addr:     HADDRS,
                    trans:    HTRANSS,
                    write:    HWRITES,
                    size:     HSIZES,
                    burst:    HBURSTS,
                    prot:     HPROTS,
                    mastlock: HMASTLOCKS};

  // Holding register: captures every loaded address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_q <= '0;
    end else if (load_c) begin
      hold_q <= live_c;
    end
  end

  // Downstream sees the held phase while pending, otherwise the live master
  assign pres_c      = pend_c ? hold_q : live_c;
  assign sel_op      = pend_c | HSELS;
  assign addr_op     = pres_c.addr;
  assign trans_op    = pres_c.trans;
  assign write_op    = pres_c.write;
  assign size_op     = pres_c.size;
  assign burst_op    = pres_c.burst;
  assign prot_op     = pres_c.prot;
  assign mastlock_op = pres_c.mastlock;

`ifdef AHB_MATRIX_IN_USER_EN
  logic [USER_W-1:0] user_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      user_q <= '0;
    end else if (load_c) begin
      user_q <= HAUSERS;
    end
  end

  assign auser_op = pend_c ? user_q : HAUSERS;
`else
  logic unused_user;

  assign unused_user = ^HAUSERS;
  assign auser_op    = '0;
`endif

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state from the pending and data-phase flag rules
  always_comb begin
    pend_nx_c   = pend_c;
    dphase_nx_c = dphase_c;
    state_d     = ST_IDLE;
    if (load_c) begin
      pend_nx_c = ~active_op;
    end else if (pend_c && active_op) begin
      pend_nx_c = 1'b0;
    end
    if (HREADYS || pend_c) begin
      dphase_nx_c = sel_op & trans_op[1] & active_op;
    end
    if (pend_nx_c) begin
      state_d = ST_HOLD;
    end else if (dphase_nx_c) begin
      state_d = ST_DATA;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Master-side response per state
  always_comb begin
    HREADYOUTS   = 1'b1;
    HRESPS       = HRESP_OKAY;
    held_tran_op = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        HREADYOUTS   = 1'b0;
        held_tran_op = 1'b1;
      end
      ST_DATA: begin
        HREADYOUTS = readyout_op;
        HRESPS     = resp_op;
      end
      default: begin
        HREADYOUTS   = 1'b1;
        HRESPS       = HRESP_OKAY;
        held_tran_op = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_matrix_input_hold.sv
// Scoreboard bench for ahb_matrix_input_hold (expects auser passthrough when AHB_MATRIX_IN_USER_EN is set).
module tb_ahb_matrix_input_hold;
  import ahb_matrix_pkg::*;

  localparam int unsigned USER_W = 32;

  logic              HCLK;
  logic              HRESETn;
  logic              HSELS;
  logic [31:0]       HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic              HMASTLOCKS;
  logic [USER_W-1:0] HAUSERS;
  logic              HREADYS;
  logic              active_op;
  logic              readyout_op;
  logic [1:0]        resp_op;
  logic              HREADYOUTS;
  logic [1:0]        HRESPS;
  logic              sel_op;
  logic [31:0]       addr_op;
  logic [1:0]        trans_op;
  logic              write_op;
  logic [2:0]        size_op;
  logic [2:0]        burst_op;
  logic [3:0]        prot_op;
  logic              mastlock_op;
  logic [USER_W-1:0] auser_op;
  logic              held_tran_op;

  ahb_matrix_input_hold #(.USER_W(USER_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HAUSERS(HAUSERS), .HREADYS(HREADYS),
    .active_op(active_op), .readyout_op(readyout_op), .resp_op(resp_op),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_op(sel_op), .addr_op(addr_op),
    .trans_op(trans_op), .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
    .prot_op(prot_op), .mastlock_op(mastlock_op), .auser_op(auser_op),
    .held_tran_op(held_tran_op)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
    logic [31:0] user;
    logic        rdy;
    logic [1:0]  resp;
    logic        held;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a pending transfer with its captured phase, and a data-phase flag
  logic        m_pend = 1'b0;
  logic        m_dph  = 1'b0;
  logic [31:0] m_addr = '0;
  logic [1:0]  m_trans = '0;
  logic        m_write = 1'b0;
  logic [2:0]  m_size = '0;
  logic [2:0]  m_burst = '0;
  logic [3:0]  m_prot = '0;
  logic        m_lock = 1'b0;
  logic [31:0] m_user = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Push this cycle's expected outputs, then advance the model across the coming edge
  task automatic apply();
    exp_t e;
    logic ld;
    logic nxt_pend;
    if (!HRESETn) begin
      m_pend = 1'b0; m_dph = 1'b0; m_addr = '0; m_trans = '0; m_write = 1'b0;
      m_size = '0; m_burst = '0; m_prot = '0; m_lock = 1'b0; m_user = '0;
    end
    e.sel   = m_pend | HSELS;
    e.addr  = m_pend ? m_addr  : HADDRS;
    e.trans = m_pend ? m_trans : HTRANSS;
    e.write = m_pend ? m_write : HWRITES;
    e.size  = m_pend ? m_size  : HSIZES;
    e.burst = m_pend ? m_burst : HBURSTS;
    e.prot  = m_pend ? m_prot  : HPROTS;
    e.lock  = m_pend ? m_lock  : HMASTLOCKS;
`ifdef AHB_MATRIX_IN_USER_EN
    e.user  = m_pend ? m_user  : HAUSERS;
`else
    e.user  = '0;
`endif
    e.rdy   = m_pend ? 1'b0 : (m_dph ? readyout_op : 1'b1);
    e.resp  = (!m_pend && m_dph) ? resp_op : HRESP_OKAY;
    e.held  = m_pend;
    exp_q.push_back(e);
    if (HRESETn) begin
      ld = HSELS & HTRANSS[1] & HREADYS;
      nxt_pend = ld ? ~active_op : ((m_pend && active_op) ? 1'b0 : m_pend);
      if (HREADYS || m_pend) m_dph = e.sel & e.trans[1] & active_op;
      m_pend = nxt_pend;
      if (ld) begin
        m_addr = HADDRS; m_trans = HTRANSS; m_write = HWRITES; m_size = HSIZES;
        m_burst = HBURSTS; m_prot = HPROTS; m_lock = HMASTLOCKS; m_user = HAUSERS;
      end
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_in();
    HSELS = 1'b0; HADDRS = 32'h0; HTRANSS = HTRANS_IDLE; HWRITES = 1'b0;
    HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTLOCKS = 1'b0; HAUSERS = '0;
    HREADYS = 1'b1; active_op = 1'b0; readyout_op = 1'b1; resp_op = HRESP_OKAY;
  endtask

  task automatic nonseq(input logic [31:0] a, input logic wr, input logic act);
    idle_in();
    HSELS = 1'b1; HADDRS = a; HTRANSS = HTRANS_NONSEQ; HWRITES = wr; active_op = act;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sel_op",       32'(sel_op),       32'(e.sel));
        chk("addr_op",      addr_op,           e.addr);
        chk("trans_op",     32'(trans_op),     32'(e.trans));
        chk("write_op",     32'(write_op),     32'(e.write));
        chk("size_op",      32'(size_op),      32'(e.size));
        chk("burst_op",     32'(burst_op),     32'(e.burst));
        chk("prot_op",      32'(prot_op),      32'(e.prot));
        chk("mastlock_op",  32'(mastlock_op),  32'(e.lock));
        chk("auser_op",     auser_op,          e.user);
        chk("HREADYOUTS",   32'(HREADYOUTS),   32'(e.rdy));
        chk("HRESPS",       32'(HRESPS),       32'(e.resp));
        chk("held_tran_op", 32'(held_tran_op), 32'(e.held));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected end within budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_rdy;
    idle_in();
    HRESETn = 1'b0;
    tick();

    // Reset state
    resp_op = HRESP_ERROR; HADDRS = 32'h1234_5678;
    apply(); #3;
    chk("rst_ready", 32'(HREADYOUTS), 32'd1);
    chk("rst_resp",  32'(HRESPS), 32'd0);
    chk("rst_held",  32'(held_tran_op), 32'd0);
    chk("rst_addr_live", addr_op, 32'h1234_5678);
    tick();
    HRESETn = 1'b1; idle_in(); apply(); tick();

    // Zero-latency NONSEQ read
    nonseq(32'h0000_0100, 1'b0, 1'b1);
    apply(); #3;
    chk("nz_sel",  32'(sel_op), 32'd1);
    chk("nz_addr", addr_op, 32'h0000_0100);
    chk("nz_held", 32'(held_tran_op), 32'd0);
    tick();
    idle_in(); readyout_op = 1'b0; HREADYS = 1'b0;
    apply(); #3;
    chk("nz_data_wait", 32'(HREADYOUTS), 32'd0);
    tick();
    idle_in(); apply(); #3;
    chk("nz_data_done", 32'(HREADYOUTS), 32'd1);
    tick();

    // Held NONSEQ write with user data
    nonseq(32'h0000_2000, 1'b1, 1'b0); HAUSERS = 32'hA5A5_A5A5;
    apply(); tick();
    for (int i = 0; i < 3; i++) begin
      idle_in(); HSELS = 1'b1; HTRANSS = 2'($urandom); HADDRS = $urandom; HAUSERS = $urandom;
      HREADYS = 1'b0;
      apply(); #3;
      chk("hold_held",  32'(held_tran_op), 32'd1);
      chk("hold_ready", 32'(HREADYOUTS), 32'd0);
      chk("hold_addr",  addr_op, 32'h0000_2000);
      chk("hold_write", 32'(write_op), 32'd1);
`ifdef AHB_MATRIX_IN_USER_EN
      chk("hold_user",  auser_op, 32'hA5A5_A5A5);
`else
      chk("hold_user",  auser_op, 32'h0);
`endif
      tick();
    end
    idle_in(); HREADYS = 1'b0; active_op = 1'b1; HADDRS = 32'hFFFF_0000;
    apply(); #3;
    chk("launch_addr", addr_op, 32'h0000_2000);
    chk("launch_sel",  32'(sel_op), 32'd1);
    tick();
    idle_in(); apply(); #3;
    chk("launch_data_ready", 32'(HREADYOUTS), 32'd1);
    chk("launch_data_held",  32'(held_tran_op), 32'd0);
    tick();

    // Two-cycle ERROR response
    nonseq(32'h0000_3000, 1'b0, 1'b1); apply(); tick();
    idle_in(); resp_op = HRESP_ERROR; readyout_op = 1'b0; HREADYS = 1'b0;
    apply(); #3;
    chk("err1_resp",  32'(HRESPS), 32'd1);
    chk("err1_ready", 32'(HREADYOUTS), 32'd0);
    tick();
    idle_in(); resp_op = HRESP_ERROR; readyout_op = 1'b1;
    apply(); #3;
    chk("err2_resp",  32'(HRESPS), 32'd1);
    chk("err2_ready", 32'(HREADYOUTS), 32'd1);
    tick();

    // BUSY during DATA leaves nothing pending
    nonseq(32'h0000_4000, 1'b0, 1'b1); apply(); tick();
    idle_in(); HSELS = 1'b1; HTRANSS = HTRANS_BUSY; active_op = 1'b1;
    apply(); #3;
    chk("busy_held", 32'(held_tran_op), 32'd0);
    tick();
    idle_in(); resp_op = HRESP_ERROR;
    apply(); #3;
    chk("busy_after_resp", 32'(HRESPS), 32'd0);
    chk("busy_after_held", 32'(held_tran_op), 32'd0);
    tick();

    // Reset pulse mid-HOLD
    nonseq(32'h0000_5000, 1'b0, 1'b0); apply(); tick();
    idle_in(); HREADYS = 1'b0; resp_op = HRESP_ERROR; HRESETn = 1'b0;
    apply(); #3;
    chk("rst_hold_held",  32'(held_tran_op), 32'd0);
    chk("rst_hold_ready", 32'(HREADYOUTS), 32'd1);
    chk("rst_hold_resp",  32'(HRESPS), 32'd0);
    tick();
    HRESETn = 1'b1; idle_in(); HSELS = 1'b1; active_op = 1'b1;
    apply(); #3;
    chk("rst_idle_ready", 32'(HREADYOUTS), 32'd1);
    tick();

    // Reset pulse mid-DATA
    nonseq(32'h0000_6000, 1'b0, 1'b1); apply(); tick();
    idle_in(); readyout_op = 1'b0; resp_op = HRESP_ERROR; HREADYS = 1'b0; HRESETn = 1'b0;
    apply(); #3;
    chk("rst_data_ready", 32'(HREADYOUTS), 32'd1);
    chk("rst_data_resp",  32'(HRESPS), 32'd0);
    tick();
    HRESETn = 1'b1; idle_in(); apply(); tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      HRESETn     = ($urandom_range(0, 99) != 0);
      HSELS       = ($urandom_range(0, 3) != 0);
      HTRANSS     = 2'($urandom);
      HADDRS      = $urandom;
      HWRITES     = 1'($urandom);
      HSIZES      = 3'($urandom);
      HBURSTS     = 3'($urandom);
      HPROTS      = 4'($urandom);
      HMASTLOCKS  = 1'($urandom);
      HAUSERS     = $urandom;
      active_op   = ($urandom_range(0, 2) != 0);
      readyout_op = ($urandom_range(0, 3) != 0);
      resp_op     = ($urandom_range(0, 7) == 0) ? HRESP_ERROR : HRESP_OKAY;
      exp_rdy     = m_pend ? 1'b0 : (m_dph ? readyout_op : 1'b1);
      HREADYS     = ($urandom_range(0, 9) == 0) ? 1'($urandom) : exp_rdy;
      apply();
      tick();
    end

    HRESETn = 1'b1; idle_in(); apply(); tick();
    @(negedge HCLK); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
